// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED status arbiter: FSM state encoding,
// requester count and the fixed-priority winner helper.
package led_ctrl_pkg;

  // Number of display requesters; index 0 has the highest priority.
  localparam int unsigned NUM_REQ = 3;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HOLD = 2'b01,
    OWN  = 2'b10
  } led_state_e;

  // Isolate the lowest set request bit: lowest index wins, and the result
  // is one-hot (or zero when nothing is requested) by construction.
  function automatic logic [NUM_REQ-1:0] pick_winner(input logic [NUM_REQ-1:0] r);
    pick_winner = r & (~r + NUM_REQ'(1));
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Blink prescaler: counts CLK_DIV clock cycles per tick, emits a registered
// one-cycle tick pulse and a phase bit that flips on every tick.
module led_tick_gen #(
  parameter int unsigned CLK_DIV = 25000000
) (
  input  logic clk,
  input  logic rstn,
  output logic tick,
  output logic phase
);

  localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          phase_q, phase_d;
  logic          wrap_s;

  // Next-state: count up to LAST, then wrap and raise tick / flip phase.
  always_comb begin
    wrap_s  = (cnt_q == LAST);
    tick_d  = wrap_s;
    phase_d = phase_q ^ wrap_s;
    if (wrap_s) begin
      cnt_d = {CW{1'b0}};
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Prescaler state registers with asynchronous clear.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q   <= {CW{1'b0}};
      tick_q  <= 1'b0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
    end
  end

  assign tick  = tick_q;
  assign phase = phase_q;

endmodule

// File: rtl/led_status_arbiter.sv
// LED status arbiter: three prioritized requesters compete for one
// two-bit LED. A new owner is held for a minimum number of blink ticks
// before it can be pre-empted; its pattern and blink enable are latched
// at grant time.
module led_status_arbiter
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 25000000,
  parameter int unsigned HOLD_TICKS = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         pat0,
  input  logic [1:0]         pat1,
  input  logic [1:0]         pat2,
  input  logic [NUM_REQ-1:0] blink,
  output logic [NUM_REQ-1:0] grant,
  output logic [1:0]         led,
  output logic               tick
);

  localparam int unsigned HW = $clog2(HOLD_TICKS + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

  led_state_e         state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [1:0]         pat_q, pat_d;
  logic               blink_q, blink_d;
  logic [HW-1:0]      hold_q, hold_d;
  logic [1:0]         led_q, led_d;

  logic               tick_s;
  logic               phase_s;
  logic [NUM_REQ-1:0] win_s;
  logic [1:0]         win_pat_s;
  logic               win_blink_s;
  logic               higher_s;
  logic               own_s;

  led_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rstn  (rstn),
    .tick  (tick_s),
    .phase (phase_s)
  );

  // Arbitration, hold countdown and LED drive for the next cycle.
  always_comb begin
    win_s       = pick_winner(req);
    win_blink_s = |(blink & win_s);
    if (win_s[0]) begin
      win_pat_s = pat0;
    end else if (win_s[1]) begin
      win_pat_s = pat1;
    end else if (win_s[2]) begin
      win_pat_s = pat2;
    end else begin
      win_pat_s = 2'b00;
    end
    // Bits below the owner's one-hot position are the higher-priority ones.
    higher_s = |(req & (grant_q - NUM_REQ'(1)));
    own_s    = |(req & grant_q);

    state_d = state_q;
    grant_d = grant_q;
    pat_d   = pat_q;
    blink_d = blink_q;
    hold_d  = hold_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = HOLD;
          grant_d = win_s;
          pat_d   = win_pat_s;
          blink_d = win_blink_s;
          hold_d  = HOLD_LOAD;
        end else begin
          grant_d = {NUM_REQ{1'b0}};
          pat_d   = 2'b00;
          blink_d = 1'b0;
        end
      end
      HOLD: begin
        // Non-preemptible: request changes are ignored until the count expires.
        if (hold_q == {HW{1'b0}}) begin
          state_d = OWN;
        end else if (tick_s) begin
          hold_d = hold_q - HW'(1);
        end else begin
          hold_d = hold_q;
        end
      end
      OWN: begin
        if (higher_s || !own_s) begin
          if (|req) begin
            state_d = HOLD;
            grant_d = win_s;
            pat_d   = win_pat_s;
            blink_d = win_blink_s;
            hold_d  = HOLD_LOAD;
          end else begin
            state_d = IDLE;
            grant_d = {NUM_REQ{1'b0}};
            pat_d   = 2'b00;
            blink_d = 1'b0;
          end
        end else begin
          state_d = OWN;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_REQ{1'b0}};
        pat_d   = 2'b00;
        blink_d = 1'b0;
        hold_d  = {HW{1'b0}};
      end
    endcase

    if (state_d == IDLE) begin
      led_d = 2'b00;
    end else if (!blink_d) begin
      led_d = pat_d;
    end else if (phase_s) begin
      led_d = pat_d;
    end else begin
      led_d = 2'b00;
    end
  end

  // Arbiter state, latched owner attributes and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      grant_q <= {NUM_REQ{1'b0}};
      pat_q   <= 2'b00;
      blink_q <= 1'b0;
      hold_q  <= {HW{1'b0}};
      led_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      pat_q   <= pat_d;
      blink_q <= blink_d;
      hold_q  <= hold_d;
      led_q   <= led_d;
    end
  end

  assign grant = grant_q;
  assign led   = led_q;
  assign tick  = tick_s;

endmodule

// File: doc/led_status_arbiter.md
LED_STATUS_ARBITER -- requirements
Module: led_status_arbiter

Interface
REQ-001 Parameter CLK_DIV, default 25000000, clk cycles per blink tick (>=2).
REQ-002 Parameter HOLD_TICKS, default 4, minimum ticks a new grant is held (>=1).
REQ-003 clk  input  1  single system clock, rising-edge.
REQ-004 rstn  input  1  asynchronous active-low reset.
REQ-005 req  input  3  per-requester display request; req[0] highest priority.
REQ-006 pat0, pat1, pat2  input  2 each  requested LED pattern of requester 0/1/2.
REQ-007 blink  input  3  per-requester blink enable.
REQ-008 grant  output  3  one-hot current owner, registered; 0 when idle.
REQ-009 led  output  2  LED drive, registered.
REQ-010 tick  output  1  one-cycle prescaler pulse, registered.

Function
REQ-011 Prescaler counts 0..CLK_DIV-1, wraps to 0; tick=1 exactly in the cycle after the count equals CLK_DIV-1.
REQ-012 Blink phase register toggles on every tick.
REQ-013 FSM states: IDLE, HOLD, OWN.
REQ-014 IDLE: grant=0, led=0; if any req=1, next cycle grant = highest-priority asserted requester, go HOLD.
REQ-015 On grant, pattern and blink bit of the winner are latched; later input changes have no effect until the next grant.
REQ-016 HOLD: hold counter loaded with HOLD_TICKS on grant, decremented per tick; at 0, go OWN in the following cycle.
REQ-017 HOLD is non-preemptible; a drop of the owner's req or a higher-priority req is ignored until HOLD expires.
REQ-018 OWN: if a higher-priority req is asserted, or the owner's req is 0, re-arbitrate: next cycle grant = highest asserted req (new HOLD), or IDLE if none.
REQ-019 OWN with owner req=1 and no higher req: grant unchanged, no relatch.
REQ-020 led = latched pattern when latched blink=0; when 1, latched pattern while phase=1, else 2'b00.
REQ-021 Latency: req rising in IDLE at cycle n gives grant and led valid at n+1.
REQ-022 Simultaneous tick and grant load: load wins, and the counter holds HOLD_TICKS.
REQ-023 grant is always one-hot or zero; never multi-hot.

Reset
REQ-024 rstn=0 asynchronously clears prescaler, phase, hold counter, latches; state=IDLE; grant=0, led=0, tick=0.
REQ-025 Reset asserted mid-HOLD/OWN aborts immediately; after release, behaviour is as from power-up (first tick after CLK_DIV cycles).

Structure
REQ-026 Shared package led_ctrl_pkg holds the FSM state enum (IDLE/HOLD/OWN) and the requester count constant (3).
REQ-027 Prescaler and phase live in sub-module led_tick_gen (clk, rstn, tick, phase); arbiter/FSM stays in the top module.

Verification (CLK_DIV=4, HOLD_TICKS=2)
REQ-028 Reset release, no req -> tick pulses every 4 cycles, grant=0, led=00 throughout.
REQ-029 req=3'b010, pat1=2'b11, blink=0 -> the next cycle grant=010, led=11; FSM reaches OWN after 2 ticks.
REQ-030 In HOLD for requester 2, assert req[0] -> grant stays 100 until HOLD expires, then grant=001 one cycle after OWN entry.
REQ-031 Owner 1 in OWN with blink=1, pat1=2'b01 -> led alternates 01/00 each tick; drop req[1] with none pending -> grant=0, led=00 next cycle.
REQ-032 Assert rstn=0 mid-OWN -> grant=0, led=00, tick=0 with no clock edge; after release, first tick 4 cycles later.
